// File: rtl/online_otf_converter.sv
// rtl/online_otf_converter.sv - MSD-first radix-2 signed-digit stream to two's-complement word
// On-the-fly conversion keeps Q and QM = Q-1 so each digit is a shift-and-append, with no carry chain.
module online_otf_converter #(
   parameter int Stage = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [1:0]     in_digit,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Stage:0] out_data
);

   localparam int W  = Stage + 1;
   localparam int CW = $clog2(Stage + 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    q, qm, q_nxt, qm_nxt;
   logic [CW-1:0]   cnt;
   logic            accept, last, d_pos, d_neg;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && (state == ACCUM);
   assign last      = (cnt == CW'(Stage - 1));

   // 2'b11 decodes to zero: both flags drop out
   assign d_pos = in_digit[1] & ~in_digit[0];
   assign d_neg = in_digit[0] & ~in_digit[1];

   always_comb begin
      q_nxt  = {q[W-2:0], 1'b0};
      qm_nxt = {qm[W-2:0], 1'b1};
      if (d_pos) begin
         q_nxt  = {q[W-2:0], 1'b1};
         qm_nxt = {q[W-2:0], 1'b0};
      end else if (d_neg) begin
         q_nxt  = {qm[W-2:0], 1'b1};
         qm_nxt = {qm[W-2:0], 1'b0};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (accept && last) state_nxt = HOLD;
         HOLD:    if (out_ready)      state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
      if (clr) state_nxt = ACCUM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ACCUM;
         cnt      <= '0;
         q        <= '0;
         qm       <= '1;
         out_data <= '0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            cnt      <= '0;
            q        <= '0;
            qm       <= '1;
            out_data <= '0;
         end else if (accept) begin
            if (last) begin
               out_data <= q_nxt;
               cnt      <= '0;
               q        <= '0;
               qm       <= '1;
            end else begin
               cnt <= cnt + CW'(1);
               q   <= q_nxt;
               qm  <= qm_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_online_otf_converter.sv
// tb/tb_online_otf_converter.sv - self-checking bench for online_otf_converter
module tb_online_otf_converter;

   localparam int Stage = 4;
   localparam int W     = Stage + 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clr = 1'b0;
   logic         in_valid = 1'b0;
   logic [1:0]   in_digit = 2'b00;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;

   int checks = 0;
   int errors = 0;

   // behavioural model: arithmetic sum of weighted digits
   bit           m_hold = 1'b0;
   int           m_cnt  = 0;
   int           m_sum  = 0;
   logic [W-1:0] m_out  = '0;

   // literal expectations handed to the compare process
   int           lit_seq  = 0;
   int           lit_done = 0;
   string        lit_name = "";
   logic         lit_valid = 1'b0;
   logic [W-1:0] lit_data = '0;

   online_otf_converter #(.Stage(Stage)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_digit  (in_digit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   function automatic int dval(input logic [1:0] d);
      case (d)
         2'b10:   return 1;
         2'b01:   return -1;
         default: return 0;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n || clr) begin
            m_hold = 1'b0;
            m_cnt  = 0;
            m_sum  = 0;
            m_out  = '0;
         end else if (!m_hold) begin
            if (in_valid) begin
               m_sum = m_sum + dval(in_digit) * (1 << (Stage - 1 - m_cnt));
               m_cnt = m_cnt + 1;
               if (m_cnt == Stage) begin
                  m_out  = W'(m_sum);
                  m_hold = 1'b1;
                  m_cnt  = 0;
                  m_sum  = 0;
               end
            end
         end else if (out_ready) begin
            m_hold = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         checks = checks + 3;
         if (in_ready !== !m_hold) begin
            errors = errors + 1;
            $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, !m_hold);
         end
         if (out_valid !== m_hold) begin
            errors = errors + 1;
            $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_hold);
         end
         if (out_data !== m_out) begin
            errors = errors + 1;
            $display("FAIL out_data t=%0t got %b want %b", $time, out_data, m_out);
         end
         if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            checks = checks + 1;
            if (out_valid !== lit_valid || (lit_valid && out_data !== lit_data)) begin
               errors = errors + 1;
               $display("FAIL %s got valid=%b data=%b want valid=%b data=%b",
                        lit_name, out_valid, out_data, lit_valid, lit_data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lit(input string nm, input logic v, input logic [W-1:0] d);
      lit_name  = nm;
      lit_valid = v;
      lit_data  = d;
      lit_seq   = lit_seq + 1;
   endtask

   // digits packed MSD first in the top bits; out_ready held low until the result is pinned
   task automatic send_word(input logic [2*Stage-1:0] ds, input string nm, input logic [W-1:0] want);
      out_ready = 1'b0;
      for (int i = Stage - 1; i >= 0; i--) begin
         in_valid = 1'b1;
         in_digit = ds[2*i +: 2];
         step();
      end
      in_valid = 1'b0;
      expect_lit(nm, 1'b1, want);
   endtask

   task automatic drain();
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      step();
      expect_lit("reset_state", 1'b0, '0);
      step();
      rst_n = 1'b1;
      step();

      send_word({2'b10, 2'b01, 2'b00, 2'b10}, "word_p5", 5'b00101);
      drain();
      send_word({2'b01, 2'b01, 2'b01, 2'b01}, "word_m15", 5'b10001);
      drain();
      send_word({2'b10, 2'b10, 2'b10, 2'b10}, "word_p15", 5'b01111);
      drain();
      send_word({2'b11, 2'b00, 2'b11, 2'b00}, "word_cancel", 5'b00000);
      drain();
      send_word({2'b00, 2'b00, 2'b00, 2'b01}, "word_m1", 5'b11111);

      // backpressure: digits offered while held must be ignored
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_digit = 2'b10;
         step();
      end
      in_valid = 1'b0;
      expect_lit("hold_stable", 1'b1, 5'b11111);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      send_word({2'b00, 2'b10, 2'b00, 2'b01}, "after_bp", 5'b00011);
      drain();

      // async reset mid-word
      in_valid = 1'b1;
      in_digit = 2'b01;
      step();
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      send_word({2'b10, 2'b00, 2'b00, 2'b00}, "after_rst", 5'b01000);
      drain();

      // clr mid-word
      in_valid = 1'b1;
      in_digit = 2'b10;
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      in_valid = 1'b0;
      send_word({2'b10, 2'b00, 2'b00, 2'b00}, "after_clr", 5'b01000);

      // clr while holding
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      expect_lit("clr_in_hold", 1'b0, '0);
      step();

      for (int w = 0; w < 1000; w++) begin
         for (int i = 0; i < Stage; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            in_valid = 1'b1;
            in_digit = 2'($urandom_range(0, 3));
            step();
         end
         in_valid  = 1'b0;
         out_ready = 1'b0;
         repeat ($urandom_range(0, 2)) step();
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end

      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
